// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the signals of the instruction-fetch stage. It carries
//               the instruction-memory address/data pair, the stall and
//               redirect controls coming back from later stages, and the
//               IF/ID register contents handed to decode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   imem_address      fetch -> memory  word address to instruction memory
//   imem_instruction  memory -> fetch  word at the address sampled last edge
//   stall             ctrl -> fetch    hold PC and IF/ID
//   branch_taken      ctrl -> fetch    redirect to ifid_pc + 1 + branch_offset
//   branch_offset     ctrl -> fetch    signed word offset (low bits used)
//   jump              ctrl -> fetch    redirect to jump_target
//   jump_target       ctrl -> fetch    word target (low bits used)
//   ifid_instruction  fetch -> decode  instruction to decode
//   ifid_pc           fetch -> decode  word address of ifid_instruction
//   ifid_valid        fetch -> decode  ifid_instruction is a real fetch
// Modports:
//   master  the fetch unit itself
//   slave   its environment (memory, hazard/branch control, decode)
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0] imem_instruction;
  logic                  stall;
  logic                  branch_taken;
  logic [15:0]           branch_offset;
  logic                  jump;
  logic [25:0]           jump_target;
  logic [DATA_WIDTH-1:0] ifid_instruction;
  logic [ADDR_WIDTH-1:0] ifid_pc;
  logic                  ifid_valid;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  stall,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_target,
    output ifid_instruction,
    output ifid_pc,
    output ifid_valid
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output stall,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_target,
    input  ifid_instruction,
    input  ifid_pc,
    input  ifid_valid
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the program counter, drives the
//               address of a synchronous-read instruction memory and presents
//               an aligned instruction/PC pair to decode through the IF/ID
//               register. Supports sequential fetch, stall with address
//               replay, and branch/jump redirect with a two-bubble flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock   in   rising-edge clock shared with the instruction memory
//   reset   in   asynchronous, active-high reset
//   bus     if   fetch_unit_if.master (memory port, stall/redirect controls,
//                IF/ID outputs)
// Parameters:
//   ADDR_WIDTH  word-address width (memory depth 2**ADDR_WIDTH)
//   DATA_WIDTH  instruction width
// ============================================================================
module fetch_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] c_NOP = '0;
  localparam logic [ADDR_WIDTH-1:0] c_ONE = ADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // State
  //   r_pc        next address to hand to the memory
  //   r_mem_pc    address whose word is currently on imem_instruction
  //   r_mem_valid that word belongs to the live instruction stream
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mem_pc;
  logic                  r_mem_valid;
  logic [DATA_WIDTH-1:0] r_ifid_instruction;
  logic [ADDR_WIDTH-1:0] r_ifid_pc;
  logic                  r_ifid_valid;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_branch_target;
  logic                  w_hold;

  // Only the low address bits of the offset/target are meaningful for a
  // 2**ADDR_WIDTH-word memory; the upper bits are deliberately ignored.
  logic                  w_unused_upper_bits;
  assign w_unused_upper_bits = ^{bus.branch_offset[15:ADDR_WIDTH],
                                 bus.jump_target[25:ADDR_WIDTH]};

  // --------------------------------------------------------------------------
  // Redirect decode. Jump has priority over a simultaneous taken branch.
  // The branch target wraps naturally in ADDR_WIDTH-bit arithmetic, which
  // matches the signed offset taken modulo the memory depth.
  // --------------------------------------------------------------------------
  assign w_redirect      = bus.jump | bus.branch_taken;
  assign w_branch_target = r_ifid_pc + c_ONE + bus.branch_offset[ADDR_WIDTH-1:0];
  assign w_target        = bus.jump ? bus.jump_target[ADDR_WIDTH-1:0]
                                    : w_branch_target;

  // A stall only takes effect when no redirect is present on the same edge.
  assign w_hold = bus.stall & ~w_redirect;

  // --------------------------------------------------------------------------
  // Memory address. During a stall the word already sitting on the memory
  // output must survive, so the memory re-reads r_mem_pc; its output is then
  // unchanged on the next cycle and nothing is lost when the stall lifts.
  // Reset forces address 0 combinationally so the memory is quiet and
  // pointed at the restart address while reset is held.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.imem_address = r_pc;
    if (reset) begin
      bus.imem_address = '0;
    end else if (w_hold) begin
      bus.imem_address = r_mem_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers. Priority: reset > redirect > stall > normal advance.
  // On a redirect r_mem_pc is left alone: the in-flight word is discarded by
  // clearing r_mem_valid, and the stale address is harmless because the next
  // advancing edge overwrites it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc               <= '0;
      r_mem_pc           <= '0;
      r_mem_valid        <= 1'b0;
      r_ifid_instruction <= c_NOP;
      r_ifid_pc          <= '0;
      r_ifid_valid       <= 1'b0;
    end else if (w_redirect) begin
      r_pc               <= w_target;
      r_mem_valid        <= 1'b0;
      r_ifid_instruction <= c_NOP;
      r_ifid_pc          <= '0;
      r_ifid_valid       <= 1'b0;
    end else if (!bus.stall) begin
      r_pc               <= r_pc + c_ONE;
      r_mem_pc           <= r_pc;
      r_mem_valid        <= 1'b1;
      // A memory word that is not part of the live stream (first cycle after
      // reset, second bubble after a redirect) enters decode as a nop, so
      // bubbles never expose unknown or stale memory contents.
      r_ifid_instruction <= r_mem_valid ? bus.imem_instruction : c_NOP;
      r_ifid_pc          <= r_mem_pc;
      r_ifid_valid       <= r_mem_valid;
    end
  end

  assign bus.ifid_instruction = r_ifid_instruction;
  assign bus.ifid_pc          = r_ifid_pc;
  assign bus.ifid_valid       = r_ifid_valid;

endmodule : fetch_unit
`default_nettype wire
